// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, IMem write port and status out for imem_loader
interface imem_loader_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic              busy;
   logic              cpu_hold;
   logic              done;
   logic              err;

   // master is the host side feeding the stream; slave is the loader itself
   modport master (
      output start, byte_in, byte_valid,
      input  we, waddr, wdata, busy, cpu_hold, done, err
   );

   modport slave (
      input  start, byte_in, byte_valid,
      output we, waddr, wdata, busy, cpu_hold, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - frames a length-prefixed, XOR-checked byte stream into IMem word writes
module imem_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic         clk,
   input  logic         clrn,
   imem_loader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t            state;
   state_t            state_d;
   logic [15:0]       count;
   logic [15:0]       word_idx;
   logic [1:0]        byte_idx;
   logic [23:0]       asm_q;
   logic [7:0]        csum;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [31:0]       wdata_q;
   logic              hold_q;
   logic              err_q;

   logic [16:0]       len_full;
   logic              last_word;
   logic              word_end;
   logic              start_ok;

   // length as it will be once LEN_HI lands; one extra bit keeps the DEPTH compare honest
   assign len_full  = {1'b0, bus.byte_in, count[7:0]};
   assign last_word = (word_idx == (count - 16'd1));
   assign word_end  = (state == S_DATA) && bus.byte_valid && (byte_idx == 2'd3);
   assign start_ok  = (state == S_IDLE) && bus.start;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (bus.byte_valid) begin
               state_d = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (bus.byte_valid) begin
               if ((len_full == 17'd0) || (len_full > DEPTH_L)) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (word_end && last_word) begin
               state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (bus.byte_valid) begin
               state_d = (bus.byte_in == csum) ? S_DONE : S_ERR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         count    <= '0;
         word_idx <= '0;
         byte_idx <= '0;
         asm_q    <= '0;
         csum     <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         hold_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         we_q <= word_end;

         if (start_ok) begin
            err_q    <= 1'b0;
            hold_q   <= 1'b1;
            csum     <= '0;
            word_idx <= '0;
            byte_idx <= '0;
         end

         if ((state == S_LEN_LO) && bus.byte_valid) begin
            count[7:0] <= bus.byte_in;
         end

         if ((state == S_LEN_HI) && bus.byte_valid) begin
            count[15:8] <= bus.byte_in;
         end

         // write port registers are separate from asm_q so the next word can start immediately
         if ((state == S_DATA) && bus.byte_valid) begin
            csum     <= csum ^ bus.byte_in;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
               2'd0: asm_q[7:0]   <= bus.byte_in;
               2'd1: asm_q[15:8]  <= bus.byte_in;
               2'd2: asm_q[23:16] <= bus.byte_in;
               default: begin
                  wdata_q  <= {bus.byte_in, asm_q};
                  waddr_q  <= word_idx[ADDR_W-1:0];
                  word_idx <= word_idx + 16'd1;
               end
            endcase
         end

         // hold is only released by a clean finish; an error leaves the CPU stalled
         if (state_d == S_ERR) begin
            err_q <= 1'b1;
         end
         if (state_d == S_DONE) begin
            hold_q <= 1'b0;
         end
      end
   end

   assign bus.we       = we_q;
   assign bus.waddr    = waddr_q;
   assign bus.wdata    = wdata_q;
   assign bus.busy     = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                         (state == S_DATA)   || (state == S_CHK);
   assign bus.cpu_hold = hold_q;
   assign bus.done     = (state == S_DONE);
   assign bus.err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven frame vectors plus directed corner sequences for imem_loader
module tb_imem_loader;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;

   logic clk = 1'b0;
   logic clrn = 1'b0;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus)
   );

   typedef struct {
      logic [15:0] len;
      logic [31:0] w [3];
      int          nw;
      logic [7:0]  chk;
      int          exp_writes;
      logic        exp_err;
      int          exp_done;
      logic        exp_hold;
   } vec_t;

   vec_t vecs [6];

   int checks = 0;
   int errors = 0;
   logic [ADDR_W-1:0] wa_q [$];
   logic [31:0]       wd_q [$];
   int done_cnt = 0;

   always @(negedge clk) begin
      if (bus.we) begin
         wa_q.push_back(bus.waddr);
         wd_q.push_back(bus.wdata);
      end
      if (bus.done) done_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.byte_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      send(w[7:0]);
      send(w[15:8]);
      send(w[23:16]);
      send(w[31:24]);
   endtask

   task automatic pulse_start();
      bus.byte_valid = 1'b0;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start      = 1'b0;
   endtask

   task automatic clear_mon();
      wa_q.delete();
      wd_q.delete();
      done_cnt = 0;
   endtask

   task automatic set_vec(input int i, input logic [15:0] len, input logic [31:0] w0,
                          input logic [31:0] w1, input int nw, input logic [7:0] c,
                          input int ew, input logic ee, input int ed, input logic eh);
      vecs[i].len        = len;
      vecs[i].w[0]       = w0;
      vecs[i].w[1]       = w1;
      vecs[i].w[2]       = 32'h0;
      vecs[i].nw         = nw;
      vecs[i].chk        = c;
      vecs[i].exp_writes = ew;
      vecs[i].exp_err    = ee;
      vecs[i].exp_done   = ed;
      vecs[i].exp_hold   = eh;
   endtask

   initial begin
      logic [7:0]  fr [12];
      logic [31:0] fw [3];
      logic [7:0]  cs;
      int          bad;
      logic [31:0] w;

      // checksums are XOR of all data bytes
      set_vec(0, 16'h0002, 32'h12345678, 32'hDEADBEEF, 2, 8'h2A, 2, 1'b0, 1, 1'b0);
      set_vec(1, 16'h0002, 32'h12345678, 32'hDEADBEEF, 2, 8'h00, 2, 1'b1, 0, 1'b1);
      set_vec(2, 16'h0001, 32'h01020304, 32'h0,        1, 8'h04, 1, 1'b0, 1, 1'b0);
      set_vec(3, 16'h0000, 32'h0,        32'h0,        0, 8'h00, 0, 1'b1, 0, 1'b1);
      set_vec(4, 16'h0401, 32'h0,        32'h0,        0, 8'h00, 0, 1'b1, 0, 1'b1);
      set_vec(5, 16'h0001, 32'h000000FF, 32'h0,        1, 8'hFF, 1, 1'b0, 1, 1'b0);

      bus.start      = 1'b0;
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_flags", {31'h0, bus.we | bus.busy | bus.cpu_hold | bus.done | bus.err}, 32'h0);
      chk("reset_waddr", 32'(bus.waddr), 32'h0);
      chk("reset_wdata", bus.wdata, 32'h0);
      clrn = 1'b1;
      idle(2);

      for (int v = 0; v < 6; v++) begin
         clear_mon();
         pulse_start();
         chk($sformatf("v%0d_busy_after_start", v), {31'h0, bus.busy}, 32'h1);
         chk($sformatf("v%0d_hold_after_start", v), {31'h0, bus.cpu_hold}, 32'h1);
         chk($sformatf("v%0d_err_cleared", v), {31'h0, bus.err}, 32'h0);
         send(vecs[v].len[7:0]);
         send(vecs[v].len[15:8]);
         for (int i = 0; i < vecs[v].nw; i++) send_word(vecs[v].w[i]);
         if (vecs[v].nw > 0) send(vecs[v].chk);
         idle(4);
         chk($sformatf("v%0d_writes", v), 32'(wa_q.size()), 32'(vecs[v].exp_writes));
         for (int i = 0; i < vecs[v].exp_writes && i < wa_q.size(); i++) begin
            chk($sformatf("v%0d_waddr%0d", v, i), 32'(wa_q[i]), 32'(i));
            chk($sformatf("v%0d_wdata%0d", v, i), wd_q[i], vecs[v].w[i]);
         end
         chk($sformatf("v%0d_done", v), 32'(done_cnt), 32'(vecs[v].exp_done));
         chk($sformatf("v%0d_err", v), {31'h0, bus.err}, {31'h0, vecs[v].exp_err});
         chk($sformatf("v%0d_hold", v), {31'h0, bus.cpu_hold}, {31'h0, vecs[v].exp_hold});
         chk($sformatf("v%0d_busy_end", v), {31'h0, bus.busy}, 32'h0);
      end

      // full byte rate, N=3: we must follow each 4th byte by exactly one cycle
      fw[0] = 32'h44332211;
      fw[1] = 32'h88776655;
      fw[2] = 32'hCCBBAA99;
      for (int i = 0; i < 12; i++) begin
         w = fw[i/4];
         fr[i] = w[8*(i%4) +: 8];
      end
      clear_mon();
      pulse_start();
      send(8'h03);
      send(8'h00);
      for (int k = 0; k < 12; k++) begin
         send(fr[k]);
         chk($sformatf("fr_we_b%0d", k), {31'h0, bus.we}, {31'h0, (k % 4) == 3});
         if ((k % 4) == 3) begin
            chk($sformatf("fr_waddr_b%0d", k), 32'(bus.waddr), 32'(k / 4));
            chk($sformatf("fr_wdata_b%0d", k), bus.wdata, fw[k/4]);
         end
      end
      send(8'hCC);
      chk("fr_done_pulse", {31'h0, bus.done}, 32'h1);
      chk("fr_hold_released", {31'h0, bus.cpu_hold}, 32'h0);
      idle(1);
      chk("fr_done_one_cycle", {31'h0, bus.done}, 32'h0);
      chk("fr_writes", 32'(wa_q.size()), 32'd3);

      // stray bytes in IDLE, then start pulsed mid-word
      clear_mon();
      send(8'h01);
      send(8'h00);
      send(8'h55);
      idle(2);
      chk("stray_busy", {31'h0, bus.busy}, 32'h0);
      chk("stray_writes", 32'(wa_q.size()), 32'd0);
      pulse_start();
      send(8'h01);
      send(8'h00);
      send(8'h0D);
      send(8'hF0);
      pulse_start();
      send(8'hFE);
      send(8'hCA);
      send(8'hC9);
      idle(3);
      chk("midstart_writes", 32'(wa_q.size()), 32'd1);
      if (wa_q.size() > 0) begin
         chk("midstart_waddr", 32'(wa_q[0]), 32'h0);
         chk("midstart_wdata", wd_q[0], 32'hCAFEF00D);
      end
      chk("midstart_done", 32'(done_cnt), 32'd1);
      chk("midstart_err", {31'h0, bus.err}, 32'h0);

      // asynchronous reset after five data bytes
      clear_mon();
      pulse_start();
      send(8'h02);
      send(8'h00);
      send_word(32'h12345678);
      send(8'hAA);
      bus.byte_valid = 1'b0;
      #2 clrn = 1'b0;
      #1;
      chk("arst_flags", {31'h0, bus.we | bus.busy | bus.cpu_hold | bus.done | bus.err}, 32'h0);
      chk("arst_waddr", 32'(bus.waddr), 32'h0);
      chk("arst_wdata", bus.wdata, 32'h0);
      chk("arst_word0_written", 32'(wa_q.size()), 32'd1);
      @(negedge clk);
      clrn = 1'b1;
      idle(1);
      clear_mon();
      pulse_start();
      send(8'h01);
      send(8'h00);
      send_word(32'h0BADF00D);
      send(8'h5B);
      idle(3);
      chk("arst_reload_writes", 32'(wa_q.size()), 32'd1);
      if (wa_q.size() > 0) chk("arst_reload_waddr", 32'(wa_q[0]), 32'h0);
      chk("arst_reload_done", 32'(done_cnt), 32'd1);

      // N == DEPTH fills every address exactly once
      clear_mon();
      cs = 8'h00;
      pulse_start();
      send(8'h00);
      send(8'h04);
      for (int i = 0; i < DEPTH; i++) begin
         w = {~i[15:0], i[15:0]};
         cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
         send_word(w);
      end
      send(cs);
      idle(3);
      chk("depth_writes", 32'(wa_q.size()), 32'(DEPTH));
      bad = 0;
      for (int i = 0; i < wa_q.size(); i++) begin
         w = {~i[15:0], i[15:0]};
         if (wa_q[i] !== i[ADDR_W-1:0] || wd_q[i] !== w) bad++;
      end
      chk("depth_contents", 32'(bad), 32'd0);
      chk("depth_done", 32'(done_cnt), 32'd1);
      chk("depth_err", {31'h0, bus.err}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
